// File: rtl/fetch_align_if.sv
// Instruction-memory read port between the fetch stage (master) and memory (slave).
// The memory returns the word one cycle after an enabled request and holds it while idle.
interface fetch_align_if #(
    parameter int unsigned PC_W = 32
);
    logic [PC_W-1:0] imem_addr;
    logic            imem_en;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_addr,
        output imem_en,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_en,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_align.sv
// IF stage: owns the PC, issues word-aligned reads and reassembles mixed 16/32-bit
// instruction streams (including word-straddling 32-bit ones) into the IF/ID register.
module fetch_align #(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              Rst,
    fetch_align_if.master     imem,
    input  logic              hz,
    input  logic              dbg,
    input  logic              mem_hold,
    input  logic              f_stall,
    input  logic              branch,
    input  logic [PC_W-1:0]   branoff,
    input  logic              trigger_trap,
    input  logic              trap_ret,
    input  logic [PC_W-1:0]   trap_addr,
    output logic [31:0]       IF_ID_ins,
    output logic [PC_W-1:0]   IF_ID_pres_addr,
    output logic              comp_sig
);
    typedef enum logic [1:0] {StRunA, StRunU, StFillU} state_e;

    localparam logic [PC_W-1:0] RESET_WORD  = {RESET_PC[PC_W-1:2], 2'b00};
    localparam state_e          RESET_STATE = RESET_PC[1] ? StFillU : StRunA;

    state_e          state_q, state_d;
    logic [PC_W-1:0] wptr_q, wptr_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic [15:0]     hbuf_q, hbuf_d;
    logic [31:0]     ins_q, ins_d;
    logic            comp_q, comp_d;
    logic            freeze, redir, req_en;
    logic [PC_W-1:0] req_addr, target;
    logic [31:0]     w;

    assign w      = imem.imem_rdata;
    assign freeze = dbg | mem_hold | f_stall;
    assign redir  = trigger_trap | trap_ret | branch;
    assign target = (trigger_trap | trap_ret) ? trap_addr : branoff;

    always_comb begin
        state_d  = state_q;
        hbuf_d   = hbuf_q;
        pc_d     = pc_q;
        ins_d    = ins_q;
        addr_d   = addr_q;
        comp_d   = comp_q;
        req_en   = 1'b0;
        req_addr = wptr_q + PC_W'(4);
        if (Rst) begin
            req_en   = 1'b1;
            req_addr = RESET_WORD;
        end else if (!freeze) begin
            if (redir) begin
                req_en   = 1'b1;
                req_addr = {target[PC_W-1:2], 2'b00};
                ins_d    = '0;
                comp_d   = 1'b0;
                addr_d   = target;
                pc_d     = target;
                state_d  = target[1] ? StFillU : StRunA;
            end else if (!hz) begin
                unique case (state_q)
                    StRunA: begin
                        addr_d = pc_q;
                        req_en = 1'b1;
                        if (w[1:0] != 2'b11) begin
                            ins_d   = {16'h0, w[15:0]};
                            comp_d  = 1'b1;
                            hbuf_d  = w[31:16];
                            state_d = StRunU;
                            pc_d    = pc_q + PC_W'(2);
                        end else begin
                            ins_d  = w;
                            comp_d = 1'b0;
                            pc_d   = pc_q + PC_W'(4);
                        end
                    end
                    StRunU: begin
                        addr_d = pc_q;
                        if (hbuf_q[1:0] != 2'b11) begin
                            // Current word stays on the bus for the next RUN_A cycle.
                            ins_d   = {16'h0, hbuf_q};
                            comp_d  = 1'b1;
                            state_d = StRunA;
                            pc_d    = pc_q + PC_W'(2);
                        end else begin
                            ins_d  = {w[15:0], hbuf_q};
                            comp_d = 1'b0;
                            hbuf_d = w[31:16];
                            req_en = 1'b1;
                            pc_d   = pc_q + PC_W'(4);
                        end
                    end
                    StFillU: begin
                        hbuf_d  = w[31:16];
                        ins_d   = '0;
                        comp_d  = 1'b0;
                        req_en  = 1'b1;
                        state_d = StRunU;
                    end
                    default: state_d = RESET_STATE;
                endcase
            end
        end
        wptr_d = req_en ? req_addr : wptr_q;
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q <= RESET_STATE;
            wptr_q  <= RESET_WORD;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            hbuf_q  <= '0;
            ins_q   <= '0;
            comp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            hbuf_q  <= hbuf_d;
            ins_q   <= ins_d;
            comp_q  <= comp_d;
        end
    end

    assign imem.imem_addr = req_addr;
    assign imem.imem_en   = req_en;
    assign IF_ID_ins       = ins_q;
    assign IF_ID_pres_addr = addr_q;
    assign comp_sig        = comp_q;
endmodule

// File: tb/tb_fetch_align.sv
// Bench for fetch_align: an instruction-stream model decodes memory from the expected PC
// every cycle, plus directed literal expectations for each scenario.
module tb_fetch_align;
    localparam int unsigned PC_W = 32;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        hz = 1'b0, dbg = 1'b0, mem_hold = 1'b0, f_stall = 1'b0;
    logic        branch = 1'b0, trigger_trap = 1'b0, trap_ret = 1'b0;
    logic [31:0] branoff = '0, trap_addr = '0;
    logic [31:0] IF_ID_ins;
    logic [31:0] IF_ID_pres_addr;
    logic        comp_sig;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];

    fetch_align_if #(.PC_W(PC_W)) bus ();

    fetch_align #(.PC_W(PC_W), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .Rst             (Rst),
        .imem            (bus),
        .hz              (hz),
        .dbg             (dbg),
        .mem_hold        (mem_hold),
        .f_stall         (f_stall),
        .branch          (branch),
        .branoff         (branoff),
        .trigger_trap    (trigger_trap),
        .trap_ret        (trap_ret),
        .trap_addr       (trap_addr),
        .IF_ID_ins       (IF_ID_ins),
        .IF_ID_pres_addr (IF_ID_pres_addr),
        .comp_sig        (comp_sig)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr[9:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    // Stream model: what the stage must present after each edge.
    logic        c_valid = 1'b0;
    logic        c_rst, c_frz, c_hz, c_redir;
    logic [31:0] c_tgt;
    logic [31:0] m_pc, lo_ins, lo_addr;
    logic        m_pend, lo_comp;

    function automatic logic [15:0] half(input logic [31:0] a);
        logic [31:0] wd;
        wd = mem[a[9:2]];
        return a[1] ? wd[31:16] : wd[15:0];
    endfunction

    initial forever begin
        @(posedge clk);
        c_rst   = Rst;
        c_frz   = dbg | mem_hold | f_stall;
        c_hz    = hz;
        c_redir = trigger_trap | trap_ret | branch;
        c_tgt   = (trigger_trap | trap_ret) ? trap_addr : branoff;
        c_valid = 1'b1;
    end

    initial forever begin
        logic [15:0] h0;
        logic [31:0] tgt_now;
        @(negedge clk);
        if (c_valid) begin
            if (c_rst) begin
                m_pc = 32'h0; m_pend = 1'b0;
                lo_ins = '0; lo_addr = 32'h0; lo_comp = 1'b0;
            end else if (c_frz || (c_hz && !c_redir)) begin
                // outputs must hold
            end else if (c_redir) begin
                m_pc = c_tgt; m_pend = c_tgt[1];
                lo_ins = '0; lo_addr = c_tgt; lo_comp = 1'b0;
            end else if (m_pend) begin
                m_pend = 1'b0; lo_ins = '0; lo_comp = 1'b0;
            end else begin
                h0 = half(m_pc);
                lo_addr = m_pc;
                if (h0[1:0] == 2'b11) begin
                    lo_ins = {half(m_pc + 32'd2), h0}; lo_comp = 1'b0; m_pc = m_pc + 32'd4;
                end else begin
                    lo_ins = {16'h0, h0}; lo_comp = 1'b1; m_pc = m_pc + 32'd2;
                end
            end
            chk("model_ins", IF_ID_ins, lo_ins);
            chk("model_addr", IF_ID_pres_addr, lo_addr);
            chk("model_comp", {31'b0, comp_sig}, {31'b0, lo_comp});
            tgt_now = (trigger_trap | trap_ret) ? trap_addr : branoff;
            if (Rst) begin
                chk("rst_en", {31'b0, bus.imem_en}, 32'd1);
                chk("rst_addr", bus.imem_addr, 32'h0);
            end else if (dbg | mem_hold | f_stall | (hz & ~(trigger_trap | trap_ret | branch))) begin
                chk("hold_en", {31'b0, bus.imem_en}, 32'd0);
            end else if (trigger_trap | trap_ret | branch) begin
                chk("redir_en", {31'b0, bus.imem_en}, 32'd1);
                chk("redir_addr", bus.imem_addr, {tgt_now[31:2], 2'b00});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input string name, input logic [31:0] ins, input logic [31:0] addr,
                           input logic comp);
        chk({name, "_ins"}, IF_ID_ins, ins);
        chk({name, "_addr"}, IF_ID_pres_addr, addr);
        chk({name, "_comp"}, {31'b0, comp_sig}, {31'b0, comp});
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    initial begin
        clear_mem();
        // 1: reset and first instruction
        mem[0] = 32'h0010_0513;
        cyc(); cyc();
        chk("t1_rst_en", {31'b0, bus.imem_en}, 32'd1);
        chk("t1_rst_addr", bus.imem_addr, 32'h0);
        exp_out("t1_rst", 32'h0, 32'h0, 1'b0);
        Rst = 1'b0;
        cyc(); exp_out("t1_first", 32'h0010_0513, 32'h0, 1'b0);

        // 2: two RVC then a 32-bit, back to back
        Rst = 1'b1; cyc();
        clear_mem();
        mem[0] = 32'h4505_0001; mem[1] = 32'h0020_0593;
        cyc(); Rst = 1'b0;
        cyc(); exp_out("t2_c0", 32'h0000_0001, 32'h0, 1'b1);
        cyc(); exp_out("t2_c1", 32'h0000_4505, 32'h2, 1'b1);
        cyc(); exp_out("t2_w",  32'h0020_0593, 32'h4, 1'b0);

        // 3: 32-bit instruction straddling a word boundary
        Rst = 1'b1; cyc();
        clear_mem();
        mem[0] = 32'h0513_0001; mem[1] = 32'h0001_0010;
        cyc(); Rst = 1'b0;
        cyc(); exp_out("t3_c0", 32'h0000_0001, 32'h0, 1'b1);
        cyc(); exp_out("t3_str", 32'h0010_0513, 32'h2, 1'b0);
        cyc(); exp_out("t3_c1", 32'h0000_0001, 32'h6, 1'b1);

        // 4: branch to an unaligned target
        Rst = 1'b1; cyc();
        clear_mem();
        mem[0] = 32'h0000_0013; mem[8'h40] = 32'h0001_0000; mem[8'h41] = 32'h0000_0013;
        cyc(); Rst = 1'b0;
        cyc(); exp_out("t4_pre", 32'h0000_0013, 32'h0, 1'b0);
        branch = 1'b1; branoff = 32'h102;
        #1 chk("t4_req", bus.imem_addr, 32'h100);
        cyc(); exp_out("t4_b1", 32'h0, 32'h102, 1'b0);
        branch = 1'b0;
        cyc(); chk("t4_b2_ins", IF_ID_ins, 32'h0);
        cyc(); exp_out("t4_tgt", 32'h0000_0001, 32'h102, 1'b1);
        cyc(); exp_out("t4_next", 32'h0000_0013, 32'h104, 1'b0);

        // 5: hazard stall, then freeze with an ignored branch
        Rst = 1'b1; cyc();
        clear_mem();
        mem[0] = 32'h4505_0001; mem[1] = 32'h0020_0593; mem[2] = 32'h0030_0613;
        mem[8'h20] = 32'h0050_0693; mem[8'h21] = 32'h0513_0001;
        cyc(); Rst = 1'b0;
        cyc(); exp_out("t5_c0", 32'h0000_0001, 32'h0, 1'b1);
        hz = 1'b1;
        #1 chk("t5_hz_en", {31'b0, bus.imem_en}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(); exp_out("t5_hz", 32'h0000_0001, 32'h0, 1'b1);
        end
        hz = 1'b0;
        cyc(); exp_out("t5_r0", 32'h0000_4505, 32'h2, 1'b1);
        cyc(); exp_out("t5_r1", 32'h0020_0593, 32'h4, 1'b0);
        cyc(); exp_out("t5_r2", 32'h0030_0613, 32'h8, 1'b0);
        dbg = 1'b1; branch = 1'b1; branoff = 32'h40;
        #1 chk("t5_frz_en", {31'b0, bus.imem_en}, 32'd0);
        cyc(); exp_out("t5_frz0", 32'h0030_0613, 32'h8, 1'b0);
        cyc(); exp_out("t5_frz1", 32'h0030_0613, 32'h8, 1'b0);
        dbg = 1'b0; branch = 1'b0;
        cyc(); exp_out("t5_after", 32'h0, 32'hC, 1'b1);

        // 6: trap beats branch; reset in the middle of a straddle
        trigger_trap = 1'b1; trap_addr = 32'h80; branch = 1'b1; branoff = 32'h40;
        #1 chk("t6_req", bus.imem_addr, 32'h80);
        cyc(); exp_out("t6_bub", 32'h0, 32'h80, 1'b0);
        trigger_trap = 1'b0; branch = 1'b0;
        cyc(); exp_out("t6_tgt", 32'h0050_0693, 32'h80, 1'b0);
        cyc(); exp_out("t6_c", 32'h0000_0001, 32'h84, 1'b1);
        Rst = 1'b1;
        cyc(); exp_out("t6_rst", 32'h0, 32'h0, 1'b0);
        mem[0] = 32'h0000_0013;
        cyc(); Rst = 1'b0;
        cyc(); exp_out("t6_fresh", 32'h0000_0013, 32'h0, 1'b0);

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_align.md
Name: fetch_align

Overview:
- IF stage feeding the decode stage's IF/ID register.
- Owns the program counter and issues word-aligned instruction-memory reads.
- Reassembles mixed 16-bit (RVC) and 32-bit instruction streams, including 32-bit instructions that straddle a word boundary.
- Applies branch/trap redirects and hazard/freeze stalls; drives IF_ID_ins, IF_ID_pres_addr and comp_sig.

Parameters:
PC_W, 32, width of all byte addresses
RESET_PC, 32'h0000_0000, fetch address after reset (halfword aligned)

Ports:
clk  in  1  system clock
Rst  in  1  reset, synchronous, active-high
imem_addr  out  PC_W  byte address of requested word, bits[1:0]=0
imem_en  out  1  read request; memory returns word next cycle and holds rdata while imem_en=0
imem_rdata  in  32  word for address requested in previous enabled cycle
hz  in  1  decode hazard/MUL-DIV stall; hold IF/ID
dbg  in  1  debug freeze
mem_hold  in  1  memory freeze
f_stall  in  1  FPU freeze
branch  in  1  branch/jump taken in decode
branoff  in  PC_W  absolute branch target byte address
trigger_trap  in  1  trap entry
trap_ret  in  1  trap return
trap_addr  in  PC_W  trap vector or return address
IF_ID_ins  out  32  instruction to decode; RVC zero-extended in [15:0]; 0 = bubble
IF_ID_pres_addr  out  PC_W  byte address of IF_ID_ins
comp_sig  out  1  IF_ID_ins is 16-bit

Behaviour:
- One clock, clk. Rst is synchronous and active-high.
- Reset, registered at the Rst edge:
  - IF_ID_ins=0, IF_ID_pres_addr=RESET_PC, comp_sig=0, hbuf valid cleared.
  - State = RUN_A if RESET_PC[1]=0, else FILL_U.
  - While Rst=1: imem_en=1 and imem_addr={RESET_PC[PC_W-1:2],2'b00}.
- Internal registers:
  - wptr: word address currently on imem_rdata.
  - hbuf: 16 bits, upper half of a consumed word.
  - state: RUN_A, RUN_U, FILL_U.
- "Request next" means imem_addr=wptr+4, imem_en=1, wptr advances.
- "Hold" means imem_en=0 and wptr is unchanged.
- Freeze (dbg|mem_hold|f_stall):
  - Highest priority after Rst.
  - All registers hold and imem_en=0.
  - branch and trap are ignored; decode re-presents them after the freeze.
- Redirect (trigger_trap|trap_ret selects trap_addr; else branch selects branoff):
  - Trap wins over branch. Redirect wins over hz.
  - Target T: request word T[PC_W-1:2]; IF_ID_ins<=0, comp_sig<=0, IF_ID_pres_addr<=T.
  - Discard hbuf. State <= RUN_A if T[1]=0, else FILL_U.
- hz=1 with no redirect: IF_ID outputs hold, imem_en=0, state holds.
- Normal advance (no Rst, freeze, redirect or hz); w=imem_rdata, P=next PC:
  - RUN_A, w[1:0]!=2'b11: deliver {16'h0,w[15:0]}, comp_sig=1; hbuf<=w[31:16]; request next; ->RUN_U; P+=2.
  - RUN_A, w[1:0]==2'b11: deliver w, comp_sig=0; request next; stay RUN_A; P+=4.
  - RUN_U, hbuf[1:0]!=2'b11: deliver {16'h0,hbuf}, comp_sig=1; hold (w not consumed); ->RUN_A; P+=2.
  - RUN_U, hbuf[1:0]==2'b11: deliver {w[15:0],hbuf}, comp_sig=0; hbuf<=w[31:16]; request next; stay RUN_U; P+=4.
  - FILL_U: hbuf<=w[31:16]; deliver bubble (IF_ID_ins=0); request next; ->RUN_U.
- IF_ID_pres_addr is the address of the delivered instruction (pre-increment P).
- PC arithmetic is modulo 2^PC_W; wrap from all-ones to 0 is silent.
- Latency:
  - Aligned redirect: exactly 1 bubble.
  - Unaligned redirect: 2 bubbles.
  - Post-reset: first instruction registered at the first edge after Rst falls.
- Rst mid-straddle (RUN_U): hbuf is discarded; no partial instruction is ever emitted.

Test Plan:
1. RESET_PC=0, mem[0]=0x00100513 -> during Rst imem_addr=0, imem_en=1; first edge after Rst low gives IF_ID_ins=0x00100513, addr 0x0, comp_sig=0.
2. mem[0]=0x45050001, mem[4]=0x00200593 -> 0x00000001@0x0 comp=1, 0x00004505@0x2 comp=1, 0x00200593@0x4 comp=0, one per cycle; no bubbles.
3. Straddle: mem[0]=0x05130001, mem[4]=0x00010010 -> 0x00000001@0x0, 0x00100513@0x2 comp=0, 0x00000001@0x6 comp=1.
4. branch=1, branoff=0x102, mem[0x100]=0x00010000, mem[0x104]=0x00000013 -> two bubbles (IF_ID_ins=0), then 0x00000001@0x102, then 0x00000013@0x104.
5. hz=1 for 3 cycles mid-stream -> IF_ID_ins/addr/comp_sig unchanged, imem_en=0; stream resumes with no loss or duplication. dbg=1 with branch=1 -> branch ignored, outputs hold.
6. trigger_trap=1, trap_addr=0x80, and branch=1, branoff=0x40 in the same cycle -> next fetch at 0x80. Rst asserted in RUN_U -> next delivered instruction is at RESET_PC with no stale hbuf content.
